latency_mem_model: RTL and testbench

- Parametrised, synthesizable data-memory responder for the processor's data bus (MREQ/WRITE/SIZE/DAD/DDT/ACKD_n protocol).
- Replaces the bench's fixed single-latency task-based model.
- Adds independent load/store latencies, configurable depth and base, misalignment/range error reporting, and memory-mapped STDOUT/EXIT decoding as registered outputs.
- Sits between the core and the bench; the bench only observes stdout/exit.

---
 rtl/latency_mem_model.sv | 166 ++++++++++++++++
 tb/tb_latency_mem_model.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/latency_mem_model.sv
// Data-bus memory responder with independent load/store latency, lane-masked stores,
// misalignment/range error reporting and memory-mapped console/exit decoding.
module latency_mem_model #(
  parameter int                  ADDR_W      = 32,
  parameter int                  DATA_W      = 32,
  parameter int                  DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0]   BASE_ADDR   = 'h0800_0000,
  parameter int                  LOAD_LAT    = 1,
  parameter int                  STORE_LAT   = 1,
  parameter logic [ADDR_W-1:0]   STDOUT_ADDR = 'hf000_0000,
  parameter logic [ADDR_W-1:0]   EXIT_ADDR   = 'hff00_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mreq,
  input  logic              write,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack_n,
  output logic              err,
  output logic              busy,
  output logic              stdout_valid,
  output logic [7:0]        stdout_char,
  output logic              exit_req
);

  localparam int                IDXW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);
  localparam logic [3:0]        LLAT    = 4'(LOAD_LAT);
  localparam logic [3:0]        SLAT    = 4'(STORE_LAT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
    $error("latency_mem_model: LOAD_LAT must be within 1..15");
  end
  if (STORE_LAT < 1 || STORE_LAT > 15) begin : g_bad_store_lat
    $error("latency_mem_model: STORE_LAT must be within 1..15");
  end
  if (DATA_W != 32) begin : g_bad_data_w
    $error("latency_mem_model: DATA_W must be 32");
  end

  logic [31:0]       mem [DEPTH_WORDS];
  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [1:0]        cap_size;
  logic              cap_write;
  logic [31:0]       cap_wdata;

  // In IDLE the live bus is decoded so a LAT=1 request can be answered at its capture edge.
  logic [ADDR_W-1:0] a_addr;
  logic [1:0]        a_size;
  logic              a_write;
  logic [31:0]       a_wdata;
  logic [ADDR_W-1:0] off;
  logic [IDXW-1:0]   idx;
  logic [1:0]        lane;
  logic              is_stdout, is_exit, special, misal, oor, d_err;
  logic [31:0]       rword, ld_data, wd_lane;
  logic [3:0]        be;
  logic [3:0]        lat_sel;
  logic              to_ack;

  always_comb begin
    a_addr    = (state == S_IDLE) ? addr  : cap_addr;
    a_size    = (state == S_IDLE) ? size  : cap_size;
    a_write   = (state == S_IDLE) ? write : cap_write;
    a_wdata   = (state == S_IDLE) ? wdata : cap_wdata;
    off       = a_addr - BASE_ADDR;
    idx       = off[IDXW+1:2];
    lane      = a_addr[1:0];
    is_stdout = (a_addr == STDOUT_ADDR);
    is_exit   = (a_addr == EXIT_ADDR);
    special   = is_stdout || is_exit;
    misal     = ((a_size == 2'b00) && (lane != 2'b00)) || ((a_size == 2'b01) && lane[0]);
    oor       = (a_addr < BASE_ADDR) || ((off >> 2) >= DEPTH_L);
    d_err     = special ? (is_stdout && a_write && !a_size[1]) : (misal || oor);
    rword     = mem[idx];
    case (a_size)
      2'b00:   ld_data = rword;
      2'b01:   ld_data = lane[1] ? {16'h0, rword[31:16]} : {16'h0, rword[15:0]};
      default: ld_data = {24'h0, rword[{lane, 3'b000} +: 8]};
    endcase
    case (a_size)
      2'b00:   begin be = 4'b1111; wd_lane = a_wdata; end
      2'b01:   begin be = lane[1] ? 4'b1100 : 4'b0011; wd_lane = {2{a_wdata[15:0]}}; end
      default: begin be = 4'b0001 << lane; wd_lane = {4{a_wdata[7:0]}}; end
    endcase
    lat_sel = a_write ? SLAT : LLAT;
    to_ack  = ((state == S_IDLE) && mreq && (lat_sel == 4'd1)) ||
              ((state == S_WAIT) && (cnt == 4'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      cap_addr     <= '0;
      cap_size     <= 2'b00;
      cap_write    <= 1'b0;
      cap_wdata    <= 32'h0;
      ack_n        <= 1'b1;
      err          <= 1'b0;
      busy         <= 1'b0;
      rdata        <= 32'h0;
      stdout_valid <= 1'b0;
      stdout_char  <= 8'h0;
      exit_req     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mreq) begin
            cap_addr  <= addr;
            cap_size  <= size;
            cap_write <= write;
            cap_wdata <= wdata;
            busy      <= 1'b1;
            if (lat_sel == 4'd1) state <= S_ACK;
            else begin
              cnt   <= lat_sel - 4'd1;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACK;
        end
        S_ACK: begin
          ack_n        <= 1'b1;
          err          <= 1'b0;
          stdout_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (to_ack) begin
        ack_n        <= 1'b0;
        err          <= d_err;
        stdout_valid <= is_stdout && a_write && a_size[1];
        if (is_stdout && a_write && a_size[1]) stdout_char <= a_wdata[7:0];
        if (d_err) rdata <= 32'h0;
        else if (!a_write) rdata <= special ? 32'h0 : ld_data;
        if (is_exit && a_write) exit_req <= 1'b1;
      end
    end
  end

  // Stores land at the edge closing the ack cycle; err is still high then for rejected ones.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_ACK) && cap_write && !err && !special) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd_lane[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_latency_mem_model.sv
// Scoreboard bench for latency_mem_model: a byte-addressed reference model predicts
// each response, and a negedge monitor checks every ack against the queued expectation.
module tb_latency_mem_model;

  localparam int          DEPTH  = 64;
  localparam int          LLAT   = 1;
  localparam int          SLAT   = 3;
  localparam logic [31:0] BASE   = 32'h0800_0000;
  localparam logic [31:0] STDOUT = 32'hf000_0000;
  localparam logic [31:0] EXITA  = 32'hff00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mreq = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ack_n, err, busy, stdout_valid, exit_req;
  logic [7:0]  stdout_char;

  latency_mem_model #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
    .LOAD_LAT(LLAT), .STORE_LAT(SLAT), .STDOUT_ADDR(STDOUT), .EXIT_ADDR(EXITA)
  ) dut (
    .clk(clk), .rst(rst), .mreq(mreq), .write(write), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack_n(ack_n), .err(err), .busy(busy),
    .stdout_valid(stdout_valid), .stdout_char(stdout_char), .exit_req(exit_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    logic        sv;
    logic [7:0]  ch;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [7:0]  bmem [int unsigned];
  int          n_vec = 0;
  int          n_mis = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: byte-addressed memory and the access rules, no notion of lanes or states.
  function automatic exp_t model_op(input bit w, input logic [1:0] sz,
                                    input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   nb;
    bit   spc;
    nb       = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    spc      = (a == STDOUT) || (a == EXITA);
    e.cyc    = 0;
    e.sv     = w && (a == STDOUT) && (nb == 1);
    e.ch     = d[7:0];
    e.rd     = 32'h0;
    if (spc) e.err = (a == STDOUT) && w && (nb != 1);
    else     e.err = ((a % nb) != 0) || (a < BASE) || (((a - BASE) / 4) >= DEPTH);
    e.chk_rd = !w || e.err;
    if (!e.err && !spc) begin
      for (int i = 0; i < nb; i++) begin
        if (w) bmem[a + i] = d[8*i +: 8];
        else   e.rd = e.rd | (32'(bmem[a + i]) << (8 * i));
      end
    end
    return e;
  endfunction

  // Holds mreq for n captures of the same request, then waits for the last ack.
  task automatic issue(input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input int n);
    int   lat;
    int   t0;
    int   g;
    exp_t e;
    lat   = w ? SLAT : LLAT;
    write = w; size = sz; addr = a; wdata = d; mreq = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    for (int k = 0; k < n; k++) begin
      e     = model_op(w, sz, a, d);
      e.cyc = t0 + k * (lat + 1) + lat - 1;
      q.push_back(e);
    end
    repeat ((n - 1) * (lat + 1)) @(posedge clk);
    @(negedge clk);
    mreq = 1'b0;
    g = 0;
    while (busy && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (g >= 60) begin
      n_vec++; n_mis++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, expected low", g);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ack_n === 1'b0) begin
        if (q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexpected_ack: ack seen at cycle %0d, expected none", cyc);
        end else begin
          mon_e = q.pop_front();
          check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("err", {31'h0, err}, {31'h0, mon_e.err});
          if (mon_e.chk_rd) check("rdata", rdata, mon_e.rd);
          check("stdout_valid", {31'h0, stdout_valid}, {31'h0, mon_e.sv});
          if (mon_e.sv) check("stdout_char", {24'h0, stdout_char}, {24'h0, mon_e.ch});
          check("busy_at_ack", {31'h0, busy}, 32'h1);
        end
      end else if (stdout_valid !== 1'b0) begin
        n_vec++; n_mis++;
        $display("FAIL stray_stdout: stdout_valid=%b without ack, expected 0", stdout_valid);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    int          g;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ack_n", {31'h0, ack_n}, 32'h1);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_stdout_valid", {31'h0, stdout_valid}, 32'h0);
    check("rst_stdout_char", {24'h0, stdout_char}, 32'h0);
    check("rst_exit_req", {31'h0, exit_req}, 32'h0);
    mon_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 2'b00, BASE + 32'(4 * i), $urandom, 1);

    issue(1'b1, 2'b00, 32'h0800_0010, 32'hDEADBEEF, 1);
    issue(1'b0, 2'b00, 32'h0800_0010, 32'h0, 1);
    issue(1'b1, 2'b10, 32'h0800_0013, 32'h0000_005A, 1);
    issue(1'b1, 2'b01, 32'h0800_0010, 32'h0000_1234, 1);
    issue(1'b0, 2'b00, 32'h0800_0010, 32'h0, 1);
    issue(1'b0, 2'b10, 32'h0800_0013, 32'h0, 1);

    issue(1'b0, 2'b00, 32'h0800_0020, 32'h0, 3);
    issue(1'b1, 2'b00, 32'h0800_0024, 32'hCAFE_F00D, 3);
    issue(1'b0, 2'b00, 32'h0800_0024, 32'h0, 1);

    issue(1'b1, 2'b01, 32'h0800_0011, 32'h0000_BEEF, 1);
    issue(1'b0, 2'b00, 32'h0800_0010, 32'h0, 1);
    issue(1'b0, 2'b00, BASE + 32'(4 * DEPTH), 32'h0, 1);
    issue(1'b0, 2'b00, BASE - 32'd4, 32'h0, 1);
    issue(1'b1, 2'b00, BASE + 32'(4 * DEPTH - 4), 32'h0BAD_F00D, 1);
    issue(1'b0, 2'b00, BASE + 32'(4 * DEPTH - 4), 32'h0, 1);

    issue(1'b1, 2'b10, STDOUT, 32'h0000_0048, 1);
    issue(1'b1, 2'b10, STDOUT, 32'h0000_0069, 1);
    issue(1'b1, 2'b00, STDOUT, 32'h0000_0041, 1);
    issue(1'b0, 2'b00, STDOUT, 32'h0, 1);

    // Abort a store while it is counting down; it must leave no trace.
    write = 1'b1; size = 2'b00; addr = 32'h0800_0030; wdata = 32'h1111_2222; mreq = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mreq = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_ack_n", {31'h0, ack_n}, 32'h1);
    issue(1'b0, 2'b00, 32'h0800_0030, 32'h0, 1);

    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 99);
      sz = 2'($urandom_range(0, 2));
      a  = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      if (r < 50 || r >= 85) begin
        if (sz == 2'b00) a[1:0] = 2'b00;
        else if (sz == 2'b01) a[0] = 1'b0;
      end else if (r < 75 && r >= 65) begin
        a = r[0] ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63))
                 : BASE - 32'(4 * $urandom_range(1, 8));
      end else if (r >= 75) begin
        a = STDOUT;
      end
      if (r >= 85) issue(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom_range(2, 3));
      else         issue(1'($urandom_range(0, 1)), sz, a, $urandom, 1);
    end

    issue(1'b1, 2'b00, EXITA, 32'h0000_0001, 1);
    check("exit_set", {31'h0, exit_req}, 32'h1);
    issue(1'b0, 2'b00, 32'h0800_0024, 32'h0, 1);
    check("exit_sticky", {31'h0, exit_req}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("exit_cleared", {31'h0, exit_req}, 32'h0);

    g = 0;
    while (q.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("pending_acks", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
